dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter_rr_pick2.sv | 29 ++
 rtl/dmem_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter:
//   DMEMADDRW / DMEMDATAW : RAM address and data widths
//   CNTW                  : width of the burst beat counter (MAX_BURST <= 15)
//   arb_state_e           : arbiter FSM state encodings
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam int DMEMADDRW = 8;
  localparam int DMEMDATAW = 16;
  localparam int CNTW      = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_BURST_CORE = 2'b01,
    ST_BURST_HOST = 2'b10
  } arb_state_e;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Requester-side bus of the data-memory arbiter (core and host ports).
//   master modport : requesters drive req/lock/rw/addr/wdata, observe
//                    gnt/rvalid and the shared read data
//   slave modport  : the arbiter's view of the same signals
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic                 ipt_core_req;
  logic                 ipt_core_lock;
  logic                 ipt_core_rw;
  logic [DMEMADDRW-1:0] ipt_core_addr;
  logic [DMEMDATAW-1:0] ipt_core_wdata;
  logic                 ipt_host_req;
  logic                 ipt_host_lock;
  logic                 ipt_host_rw;
  logic [DMEMADDRW-1:0] ipt_host_addr;
  logic [DMEMDATAW-1:0] ipt_host_wdata;
  logic                 opt_core_gnt;
  logic                 opt_host_gnt;
  logic                 opt_core_rvalid;
  logic                 opt_host_rvalid;
  logic [DMEMDATAW-1:0] opt_rdata;

  modport master (
    output ipt_core_req, ipt_core_lock, ipt_core_rw, ipt_core_addr, ipt_core_wdata,
    output ipt_host_req, ipt_host_lock, ipt_host_rw, ipt_host_addr, ipt_host_wdata,
    input  opt_core_gnt, opt_host_gnt, opt_core_rvalid, opt_host_rvalid, opt_rdata
  );

  modport slave (
    input  ipt_core_req, ipt_core_lock, ipt_core_rw, ipt_core_addr, ipt_core_wdata,
    input  ipt_host_req, ipt_host_lock, ipt_host_rw, ipt_host_addr, ipt_host_wdata,
    output opt_core_gnt, opt_host_gnt, opt_core_rvalid, opt_host_rvalid, opt_rdata
  );

endinterface : dmem_arbiter_if

// File: rtl/dmem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin pick, purely combinational.
//   i_req_core / i_req_host : requests
//   i_ptr_host              : 1 = host wins a tie, 0 = core wins a tie
//   o_gnt                   : one-hot grant, bit 0 = core, bit 1 = host
// -----------------------------------------------------------------------------
module rr_pick2 (
  input  logic       i_req_core,
  input  logic       i_req_host,
  input  logic       i_ptr_host,
  output logic [1:0] o_gnt
);

  // Single requester always wins; the pointer only settles a tie.
  always_comb begin
    o_gnt = 2'b00;
    if (i_req_core && i_req_host) begin
      o_gnt = i_ptr_host ? 2'b10 : 2'b01;
    end else if (i_req_core) begin
      o_gnt = 2'b01;
    end else if (i_req_host) begin
      o_gnt = 2'b10;
    end else begin
      o_gnt = 2'b00;
    end
  end

endmodule : rr_pick2

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates a single-port data RAM between a core and a host requester.
// Round-robin in IDLE, locked bursts of up to MAX_BURST beats, registered
// RAM command one cycle after the grant, read data returned two cycles after
// the grant with a per-requester rvalid.
//   clk, reset                : clock, synchronous active-high reset
//   t_cs                      : global enable; 0 blocks grants and freezes the FSM
//   bus (slave)               : requester handshake, grants, rvalids, shared rdata
//   opt_arb_to_dram_*         : registered RAM command (en_b active low)
//   ipt_dram_to_arb_rdata     : RAM read data, valid one cycle after the command
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 t_cs,
  dmem_arbiter_if.slave        bus,
  output logic                 opt_arb_to_dram_en_b,
  output logic                 opt_arb_to_dram_rw,
  output logic [DMEMADDRW-1:0] opt_arb_to_dram_addr,
  output logic [DMEMDATAW-1:0] opt_arb_to_dram_wdata,
  input  logic [DMEMDATAW-1:0] ipt_dram_to_arb_rdata
);

  localparam logic [CNTW-1:0] MAX_CNT  = CNTW'(MAX_BURST);
  localparam bit              BURST_EN = (MAX_BURST > 1);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic [CNTW-1:0] w_cnt_inc;
  logic            r_ptr_host;
  logic            w_ptr_nxt;
  logic [1:0]      w_pick;
  logic            w_gnt_core;
  logic            w_gnt_host;

  logic            r_tag_vld;
  logic            r_tag_host;
  logic            r_core_rvalid;
  logic            r_host_rvalid;

  rr_pick2 u_rr_pick2 (
    .i_req_core (bus.ipt_core_req),
    .i_req_host (bus.ipt_host_req),
    .i_ptr_host (r_ptr_host),
    .o_gnt      (w_pick)
  );

  assign w_cnt_inc = r_cnt + 4'd1;

  // Next-state, counter, pointer and grant decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr_host;
    w_gnt_core  = 1'b0;
    w_gnt_host  = 1'b0;
    if (reset || !t_cs) begin
      // Disabled: nothing granted and all arbitration state frozen.
      w_state_nxt = r_state;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_gnt_core = w_pick[0];
          w_gnt_host = w_pick[1];
          if (w_pick[0]) begin
            w_ptr_nxt = 1'b1;
            if (bus.ipt_core_lock && BURST_EN) begin
              w_state_nxt = ST_BURST_CORE;
              w_cnt_nxt   = 4'd1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else if (w_pick[1]) begin
            w_ptr_nxt = 1'b0;
            if (bus.ipt_host_lock && BURST_EN) begin
              w_state_nxt = ST_BURST_HOST;
              w_cnt_nxt   = 4'd1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BURST_CORE: begin
          if (bus.ipt_core_req) begin
            // The beat that reaches the limit (or drops lock) is still granted.
            w_gnt_core = 1'b1;
            w_ptr_nxt  = 1'b1;
            if (!bus.ipt_core_lock || (w_cnt_inc == MAX_CNT)) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = 4'd0;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
          end
        end
        ST_BURST_HOST: begin
          if (bus.ipt_host_req) begin
            w_gnt_host = 1'b1;
            w_ptr_nxt  = 1'b0;
            if (!bus.ipt_host_lock || (w_cnt_inc == MAX_CNT)) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = 4'd0;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // FSM state, beat counter and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_ptr_host <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ptr_host <= w_ptr_nxt;
    end
  end

  // RAM command register; rw/addr/wdata hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      opt_arb_to_dram_en_b  <= 1'b1;
      opt_arb_to_dram_rw    <= 1'b1;
      opt_arb_to_dram_addr  <= {DMEMADDRW{1'b0}};
      opt_arb_to_dram_wdata <= {DMEMDATAW{1'b0}};
    end else if (w_gnt_core) begin
      opt_arb_to_dram_en_b  <= 1'b0;
      opt_arb_to_dram_rw    <= bus.ipt_core_rw;
      opt_arb_to_dram_addr  <= bus.ipt_core_addr;
      opt_arb_to_dram_wdata <= bus.ipt_core_wdata;
    end else if (w_gnt_host) begin
      opt_arb_to_dram_en_b  <= 1'b0;
      opt_arb_to_dram_rw    <= bus.ipt_host_rw;
      opt_arb_to_dram_addr  <= bus.ipt_host_addr;
      opt_arb_to_dram_wdata <= bus.ipt_host_wdata;
    end else begin
      opt_arb_to_dram_en_b  <= 1'b1;
    end
  end

  // Two-stage read tag pipeline: stage 1 tracks the command in flight,
  // stage 2 is the rvalid seen by the requester. It never stalls, and
  // reset flushes any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_vld     <= 1'b0;
      r_tag_host    <= 1'b0;
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_tag_vld     <= (w_gnt_core && bus.ipt_core_rw) || (w_gnt_host && bus.ipt_host_rw);
      r_tag_host    <= w_gnt_host;
      r_core_rvalid <= r_tag_vld && !r_tag_host;
      r_host_rvalid <= r_tag_vld && r_tag_host;
    end
  end

  assign bus.opt_core_gnt    = w_gnt_core;
  assign bus.opt_host_gnt    = w_gnt_host;
  assign bus.opt_core_rvalid = r_core_rvalid;
  assign bus.opt_host_rvalid = r_host_rvalid;
  // RAM data arrives in the rvalid cycle; forced to zero otherwise.
  assign bus.opt_rdata       = (r_core_rvalid || r_host_rvalid) ? ipt_dram_to_arb_rdata
                                                                : {DMEMDATAW{1'b0}};

endmodule : dmem_arbiter
